// File: rtl/mul_res_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_res_accumulator                                          |
// | Description : Accumulates signed products into dot-product results with   |
// |               a valid/ready handshake; MUL_RES_ACC_SAT_EN enables clamping |
// |               of the result to out_width (default build truncates).        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module mul_res_accumulator #(
    parameter int in_width         = 32,
    parameter int acc_width        = 40,
    parameter int out_width        = 32,
    parameter int simulation_delay = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [in_width-1:0]  in_prod,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [out_width-1:0] out_sum,
    output logic [15:0]          out_cnt,
    output logic                 out_ovf
);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;
    localparam logic [15:0] c_CNT_ONE = 16'd1;

    generate
        if (acc_width < in_width || acc_width > 64 || out_width > acc_width ||
            out_width < 2 || simulation_delay < 0) begin : g_bad_params
            $fatal(1, "mul_res_accumulator: illegal parameter combination");
        end
    endgenerate

    logic                 r_open;
    logic [acc_width-1:0] r_acc;
    logic [15:0]          r_cnt;
    logic                 r_out_valid;
    logic [out_width-1:0] r_out_sum;
    logic [15:0]          r_out_cnt;
    logic                 r_out_ovf;

    logic                 w_in_beat;
    logic                 w_out_beat;
    logic [acc_width-1:0] w_prod_ext;
    logic [acc_width-1:0] w_acc_next;
    logic [15:0]          w_cnt_next;
    logic [out_width-1:0] w_res_sum;
    logic                 w_res_ovf;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_in_beat  = in_valid && in_ready;
    assign w_out_beat = r_out_valid && out_ready;

    generate
        if (acc_width > in_width) begin : g_ext_wide
            assign w_prod_ext = {{(acc_width-in_width){in_prod[in_width-1]}}, in_prod};
        end else begin : g_ext_same
            assign w_prod_ext = in_prod;
        end
    endgenerate

    // A beat with no open accumulation starts a new group, so no clear cycle is needed.
    always_comb begin
        w_acc_next = w_prod_ext;
        w_cnt_next = c_CNT_ONE;
        if (r_open) begin
            w_acc_next = r_acc + w_prod_ext;
            w_cnt_next = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;
        end
    end

`ifdef MUL_RES_ACC_SAT_EN
    logic w_in_range;

    // In range when every bit above the result sign bit equals the accumulator sign.
    assign w_in_range = (w_acc_next[acc_width-1:out_width-1] ==
                         {(acc_width-out_width+1){w_acc_next[acc_width-1]}});

    always_comb begin
        w_res_sum = w_acc_next[out_width-1:0];
        w_res_ovf = 1'b0;
        if (!w_in_range) begin
            w_res_ovf = 1'b1;
            if (w_acc_next[acc_width-1]) begin
                w_res_sum = {1'b1, {(out_width-1){1'b0}}};
            end else begin
                w_res_sum = {1'b0, {(out_width-1){1'b1}}};
            end
        end
    end
`else
    assign w_res_sum = w_acc_next[out_width-1:0];
    assign w_res_ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_open      <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cnt   <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            if (w_in_beat) begin
                r_acc  <= w_acc_next;
                r_cnt  <= w_cnt_next;
                r_open <= !in_last;
            end
            // A closing beat wins over a retiring output beat in the same cycle.
            if (w_in_beat && in_last) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= w_res_sum;
                r_out_cnt   <= w_cnt_next;
                r_out_ovf   <= w_res_ovf;
            end else if (w_out_beat) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_cnt   = r_out_cnt;
    assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mul_res_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mul_res_accumulator                                       |
// | Description : Scoreboard bench for mul_res_accumulator (out_width = 16).   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_mul_res_accumulator;

    localparam int IW = 24;
    localparam int AW = 40;
    localparam int OW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_prod;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_sum;
    logic [15:0]   out_cnt;
    logic          out_ovf;

    mul_res_accumulator #(
        .in_width(IW), .acc_width(AW), .out_width(OW), .simulation_delay(1)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cnt(out_cnt), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint sum;
        longint cnt;
        longint ovf;
    } res_t;

    int     checks = 0;
    int     errors = 0;
    res_t   exp_q[$];
    longint grp[$];
    int     ready_mode = 1;   // 0 random, 1 always ready, 2 stalled
    bit     strict_ready = 0;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer sum, reduced modulo 2^AW, then fitted to OW bits.
    function automatic res_t model(longint terms[$]);
        res_t   r;
        longint s = 0;
        longint m = longint'(1) << AW;
        longint lo = -(longint'(1) << (OW-1));
        longint hi = (longint'(1) << (OW-1)) - 1;
        foreach (terms[i]) s += terms[i];
        s = s & (m - 1);
        if (s >= m/2) s -= m;
`ifdef MUL_RES_ACC_SAT_EN
        r.ovf = 0;
        if (s > hi) begin r.sum = hi; r.ovf = 1; end
        else if (s < lo) begin r.sum = lo; r.ovf = 1; end
        else r.sum = s;
`else
        r.ovf = 0;
        r.sum = s & ((longint'(1) << OW) - 1);
        if (r.sum > hi) r.sum -= (longint'(1) << OW);
`endif
        r.cnt = (terms.size() > 65535) ? 65535 : terms.size();
        return r;
    endfunction

    task automatic finish_now();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "bench stopped on timeout");
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(longint p, bit last);
        int waited = 0;
        in_valid = 1'b1;
        in_prod  = p[IW-1:0];
        in_last  = last;
        @(negedge clk);
        while (!in_ready) begin
            waited++;
            if (waited > 500) begin
                chk("send_timeout", waited, 0);
                finish_now();
            end
            @(negedge clk);
        end
        if (strict_ready) chk("no_bubble_wait", waited, 0);
        grp.push_back(p);
        if (last) begin
            exp_q.push_back(model(grp));
            grp.delete();
        end
        sync();
        in_valid = 1'b0;
        in_prod  = IW'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'($urandom);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: handshake rule, latency, hold stability and result scoreboard.
    initial begin
        bit            have_prev = 0;
        bit            prev_valid = 0;
        bit            prev_ready = 0;
        logic [32:0]   prev_out = '0;
        bit            pend_last = 0;
        res_t          e;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_prev = 0;
                pend_last = 0;
            end else begin
                chk("in_ready_rule", in_ready, !out_valid || out_ready);
                if (pend_last) chk("latency_valid", out_valid, 1);
                if (have_prev && prev_valid && !prev_ready) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_outputs", {out_sum, out_cnt, out_ovf}, prev_out);
                end else if (have_prev && !prev_valid && !out_valid) begin
                    chk("idle_outputs", {out_sum, out_cnt, out_ovf}, prev_out);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_sum", longint'($signed(out_sum)), e.sum);
                        chk("out_cnt", out_cnt, e.cnt);
                        chk("out_ovf", out_ovf, e.ovf);
                    end
                end
                have_prev  = 1;
                prev_valid = out_valid;
                prev_ready = out_ready;
                prev_out   = {out_sum, out_cnt, out_ovf};
                pend_last  = in_valid && in_ready && in_last;
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cnt", out_cnt, 0);
        chk("rst_out_ovf", out_ovf, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        sync();

        // Basic three-term group
        send(3, 0); send(-5, 0); send(10, 1);
        // Single term then back-to-back groups with no bubble
        strict_ready = 1;
        send(7, 1); send(1, 0); send(2, 1); send(4, 1);
        strict_ready = 0;
        drain();
        sync();

        // Stall: pending result, ignored beats while not ready
        ready_mode = 2;
        #2;
        send(100, 0); send(-3, 1);
        repeat (5) begin
            in_valid = 1'b1;
            in_prod  = IW'($urandom);
            in_last  = 1'($urandom);
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            sync();
        end
        in_valid   = 1'b0;
        ready_mode = 1;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        drain();
        sync();

        // Result width overflow
        send(30000, 0); send(30000, 1);
        send(-30000, 0); send(-30000, 1);
        drain();
        sync();

        // Reset with an unread result
        ready_mode = 2;
        #2;
        send(9, 1);
        sync();
        #2;
        rst = 1'b1;
        exp_q.delete();
        grp.delete();
        #1;
        chk("rst_drop_valid", out_valid, 0);
        chk("rst_drop_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        ready_mode = 1;
        sync();

        // Reset during a partial group
        send(11, 0); send(22, 0);
        #2;
        rst = 1'b1;
        grp.delete();
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        sync();
        send(5, 0); send(6, 1);
        drain();
        sync();

        // Randomized groups with random backpressure and idle gaps
        ready_mode = 0;
        for (int g = 0; g < 60; g++) begin
            int len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                longint p;
                if ($urandom_range(0, 1) == 0)
                    p = longint'($urandom_range(0, 2000)) - 1000;
                else
                    p = longint'($urandom_range(0, (1 << IW) - 1)) - (longint'(1) << (IW-1));
                send(p, k == len - 1);
                if ($urandom_range(0, 3) == 0) sync();
            end
        end
        ready_mode = 1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_res_accumulator.md
MUL_RES_ACCUMULATOR -- requirements
Module: mul_res_accumulator

Interface
REQ-001 SHALL have parameter in_width, default 32, signed product width incl. sign bit.
REQ-002 SHALL have parameter acc_width, default 40, internal accumulator width; in_width <= acc_width <= 64.
REQ-003 SHALL have parameter out_width, default 32, result width incl. sign bit; out_width <= acc_width.
REQ-004 SHALL have parameter simulation_delay, default 1, register update delay for simulation only.
REQ-005 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  product valid from upstream multiplier stage.
REQ-008 SHALL have port in_ready  output  1  stage can accept a product; upstream uses it as its pipeline enable.
REQ-009 SHALL have port in_prod  input  in_width  signed product.
REQ-010 SHALL have port in_last  input  1  marks final product of a dot product.
REQ-011 SHALL have port out_valid  output  1  accumulated result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out_sum  output  out_width  signed accumulated result.
REQ-014 SHALL have port out_cnt  output  16  number of products in this result.
REQ-015 SHALL have port out_ovf  output  1  result was clamped.

Function
REQ-016 SHALL accept a product only on a cycle where in_valid and in_ready are both 1 (input beat).
REQ-017 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-018 SHALL treat a beat as the first term when no accumulation is open: acc <= sign-extended in_prod, cnt <= 1; no separate clear cycle.
REQ-019 SHALL otherwise accumulate: acc <= acc + sign-extended in_prod, modulo 2^acc_width (two's-complement wrap).
REQ-020 SHALL saturate cnt at 65535; further terms still add to acc.
REQ-021 SHALL, on a beat with in_last=1, close the accumulation and assert out_valid on the next cycle (latency 1 clk from last beat).
REQ-022 SHALL hold out_valid, out_sum, out_cnt, out_ovf stable until the cycle where out_valid and out_ready are both 1 (output beat).
REQ-023 SHALL, when an output beat and an input beat occur in the same cycle, retire the old result and start a fresh accumulation with the incoming product as first term; a same-cycle in_last=1 makes out_valid stay 1 with the new one-term result.
REQ-024 SHALL deassert out_valid after an output beat when no new closing beat occurs.
REQ-025 SHALL keep out_sum, out_cnt, out_ovf at their last value while out_valid=0 (no toggling).
REQ-026 SHALL support single-term dot products (first beat has in_last=1).
REQ-027 SHALL ignore in_prod and in_last when in_valid=0.

Reset
REQ-028 SHALL, on rst=1, asynchronously clear acc, cnt, out_sum, out_cnt, out_ovf to 0 and out_valid to 0, and mark no accumulation open.
REQ-029 SHALL discard any partial accumulation or unread result when reset asserts mid-operation.
REQ-030 SHALL have in_ready=1 during and immediately after reset.

Configuration
REQ-031 SHALL, with macro MUL_RES_ACC_SAT_EN defined, clamp the closing acc to [-2^(out_width-1), 2^(out_width-1)-1] for out_sum and set out_ovf=1 iff clamping occurred.
REQ-032 SHALL, without MUL_RES_ACC_SAT_EN, set out_sum to acc[out_width-1:0] (truncation) and tie out_ovf to 0.

Verification
REQ-033 SHALL cover: products 3, -5, 10 (last on 10), out_ready=1 -> out_valid one cycle after last beat, out_sum=8, out_cnt=3, out_ovf=0.
REQ-034 SHALL cover: single beat 7 with in_last=1 -> out_sum=7, out_cnt=1; then back-to-back groups {1,2} and {4} with out_ready=1 -> results 3 then 4, no bubble, in_ready constantly 1.
REQ-035 SHALL cover: result pending with out_ready=0 for 5 cycles -> in_ready=0, outputs stable 5 cycles, in_valid beats ignored; out_ready=1 -> result accepted, in_ready=1 same cycle.
REQ-036 SHALL cover: out_width=16, products 30000 and 30000 (last) -> with MUL_RES_ACC_SAT_EN out_sum=32767, out_ovf=1; without, out_sum=-5536, out_ovf=0.
REQ-037 SHALL cover: rst pulsed after 2 of 4 products -> out_valid=0; next group {5,6 last} gives out_sum=11, out_cnt=2.
